writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue_pkg.sv | 20 ++
 rtl/writeback_queue_match.sv | 36 +++
 rtl/writeback_queue.sv | 108 ++++++++++
 tb/tb_writeback_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : writeback_queue_pkg
// Purpose  : Shared widths, default depth and entry layout for the queue.
// Revision : 1.0
// ============================================================================
package writeback_queue_pkg;

    localparam int REG_W     = 16;
    localparam int RID_W     = 4;
    localparam int WBQ_DEPTH = 4;

    typedef struct packed {
        logic             valid;
        logic [RID_W-1:0] regId;
        logic [REG_W-1:0] data;
    } wbq_entry_t;

endpackage
`default_nettype wire

// File: rtl/writeback_queue_match.sv
`default_nettype none
// ============================================================================
// Module   : wbq_match
// Purpose  : Forwarding lookup over pending entries, youngest match wins.
// Revision : 1.0
// ============================================================================
module wbq_match
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wbq_entry_t       entries [DEPTH],
    input  logic [PTR_W-1:0] head,
    input  logic [RID_W-1:0] qReg,
    output logic             hit,
    output logic [REG_W-1:0] data
);

    // Walk from oldest (head) to youngest so later matches override earlier ones.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        hit   = 1'b0;
        data  = '0;
        w_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = head + PTR_W'(k);
            if ((qReg != '0) && entries[w_idx].valid && (entries[w_idx].regId == qReg)) begin
                hit  = 1'b1;
                data = entries[w_idx].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : writeback_queue
// Purpose  : In-order writeback buffer in front of the register file write
//            port, with two forwarding lookup ports.
// Revision : 1.0
// ============================================================================
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RID_W-1:0] in_reg,
    input  logic [REG_W-1:0] in_data,
    input  logic             drain_en,
    output logic             WriteReg,
    output logic [RID_W-1:0] DstReg,
    output logic [REG_W-1:0] DstData,
    input  logic [RID_W-1:0] q1_reg,
    input  logic [RID_W-1:0] q2_reg,
    output logic             q1_hit,
    output logic             q2_hit,
    output logic [REG_W-1:0] q1_data,
    output logic [REG_W-1:0] q2_data,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    wbq_entry_t       r_entries [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;

    logic             w_nonEmpty;
    logic             w_pop;
    logic             w_push;
    logic             w_q1Hit;
    logic             w_q2Hit;
    logic [REG_W-1:0] w_q1Data;
    logic [REG_W-1:0] w_q2Data;

    assign w_nonEmpty = !rst && (r_count != '0);
    assign w_pop      = drain_en && w_nonEmpty;
    assign WriteReg   = w_pop;
    assign in_ready   = !rst && ((r_count < c_depth) || w_pop);
    // Register 0 offers complete the handshake but are never stored.
    assign w_push     = in_valid && in_ready && (in_reg != '0);

    assign DstReg  = w_nonEmpty ? r_entries[r_rdPtr].regId : '0;
    assign DstData = w_nonEmpty ? r_entries[r_rdPtr].data  : '0;
    assign count   = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else begin
            // Pop is applied first so a push into the same slot at full wins.
            if (w_pop) begin
                r_entries[r_rdPtr].valid <= 1'b0;
                r_rdPtr                  <= r_rdPtr + PTR_W'(1);
            end
            if (w_push) begin
                r_entries[r_wrPtr] <= '{valid: 1'b1, regId: in_reg, data: in_data};
                r_wrPtr            <= r_wrPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    wbq_match #(.DEPTH(DEPTH)) u_matchQ1 (
        .entries (r_entries),
        .head    (r_rdPtr),
        .qReg    (q1_reg),
        .hit     (w_q1Hit),
        .data    (w_q1Data)
    );

    wbq_match #(.DEPTH(DEPTH)) u_matchQ2 (
        .entries (r_entries),
        .head    (r_rdPtr),
        .qReg    (q2_reg),
        .hit     (w_q2Hit),
        .data    (w_q2Data)
    );

    assign q1_hit  = !rst && w_q1Hit;
    assign q2_hit  = !rst && w_q2Hit;
    assign q1_data = (!rst && w_q1Hit) ? w_q1Data : '0;
    assign q2_data = (!rst && w_q2Hit) ? w_q2Data : '0;

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_queue
// Purpose  : Directed and randomised checks of writeback_queue (DEPTH=4).
// Revision : 1.0
// ============================================================================
module tb_writeback_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_reg;
    logic [15:0] in_data;
    logic        drain_en;
    logic        WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic [3:0]  q1_reg;
    logic [3:0]  q2_reg;
    logic        q1_hit;
    logic        q2_hit;
    logic [15:0] q1_data;
    logic [15:0] q2_data;
    logic [2:0]  count;

    int r_checks = 0;
    int r_fails  = 0;

    logic [3:0]  mq_reg [$];
    logic [15:0] mq_dat [$];

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_reg   (in_reg),
        .in_data  (in_data),
        .drain_en (drain_en),
        .WriteReg (WriteReg),
        .DstReg   (DstReg),
        .DstData  (DstData),
        .q1_reg   (q1_reg),
        .q2_reg   (q2_reg),
        .q1_hit   (q1_hit),
        .q2_hit   (q2_hit),
        .q1_data  (q1_data),
        .q2_data  (q2_data),
        .count    (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] r, input logic [15:0] d);
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    function automatic void modelLookup(input logic [3:0] id, output logic hit, output logic [15:0] d);
        hit = 1'b0;
        d   = '0;
        if (id != 0) begin
            for (int i = 0; i < mq_reg.size(); i++) begin
                if (mq_reg[i] == id) begin
                    hit = 1'b1;
                    d   = mq_dat[i];
                end
            end
        end
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_reg = 4'd5; in_data = 16'h5555;
        drain_en = 1'b1; q1_reg = 4'd5; q2_reg = 4'd0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_write",    WriteReg, 0);
        check("rst_count",    count, 0);
        check("rst_dstdata",  DstData, 0);
        check("rst_q1_hit",   q1_hit, 0);

        // Single push then drain
        rst = 1'b0; in_valid = 1'b0; q1_reg = 0;
        #1;
        in_valid = 1'b1; in_reg = 4'd3; in_data = 16'h1234;
        #1;
        check("s1_ready",      in_ready, 1);
        check("s1_no_passthr", WriteReg, 0);
        tick();
        in_valid = 1'b0;
        #1;
        check("s1_write",   WriteReg, 1);
        check("s1_dstreg",  DstReg, 3);
        check("s1_dstdata", DstData, 16'h1234);
        check("s1_count1",  count, 1);
        tick();
        check("s1_count0",  count, 0);
        check("s1_idle",    WriteReg, 0);
        check("s1_dst0",    DstReg, 0);

        // Fill to full, hold fifth, then push+pop at full
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) offer(4'(i), 16'h0100 + 16'(i));
        check("s2_full_count", count, 4);
        check("s2_full_ready", in_ready, 0);
        in_valid = 1'b1; in_reg = 4'd5; in_data = 16'h0105;
        #1;
        check("s2_held_ready", in_ready, 0);
        tick();
        check("s2_held_count", count, 4);
        drain_en = 1'b1;
        #1;
        check("s2_pp_ready", in_ready, 1);
        check("s2_pp_write", WriteReg, 1);
        check("s2_pp_reg",   DstReg, 1);
        tick();
        in_valid = 1'b0;
        #1;
        check("s2_pp_count", count, 4);
        for (int i = 2; i <= 5; i++) begin
            check("s2_order_reg",  DstReg, 32'(i));
            check("s2_order_data", DstData, 32'h0100 + 32'(i));
            check("s2_order_we",   WriteReg, 1);
            tick();
        end
        check("s2_empty", count, 0);

        // Forwarding: youngest match wins; id 0 never hits
        drain_en = 1'b0;
        offer(4'd7, 16'h0001);
        offer(4'd7, 16'h0002);
        q1_reg = 4'd7; q2_reg = 4'd0;
        #1;
        check("s3_q1_hit",  q1_hit, 1);
        check("s3_q1_data", q1_data, 16'h0002);
        check("s3_q2_hit",  q2_hit, 0);
        check("s3_q2_data", q2_data, 0);
        drain_en = 1'b1;
        tick();
        check("s3_after1_hit",  q1_hit, 1);
        check("s3_after1_data", q1_data, 16'h0002);
        check("s3_popping_hit", q1_hit, 1);
        tick();
        check("s3_after2_hit",  q1_hit, 0);
        check("s3_after2_data", q1_data, 0);

        // Register 0 offer is accepted and discarded
        in_valid = 1'b1; in_reg = 4'd0; in_data = 16'hFFFF;
        #1;
        check("s4_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        check("s4_count", count, 0);
        check("s4_write", WriteReg, 0);
        tick();
        check("s4_write2", WriteReg, 0);

        // Reset mid-drain discards pending entries
        drain_en = 1'b0;
        offer(4'd1, 16'h0011);
        offer(4'd2, 16'h0022);
        offer(4'd3, 16'h0033);
        drain_en = 1'b1;
        #1;
        check("s5_first_pop", DstReg, 1);
        tick();
        rst = 1'b1; q1_reg = 4'd2;
        #1;
        check("s5_rst_write", WriteReg, 0);
        check("s5_rst_ready", in_ready, 0);
        check("s5_rst_hit",   q1_hit, 0);
        tick();
        rst = 1'b0;
        #1;
        check("s5_count", count, 0);
        check("s5_write", WriteReg, 0);
        check("s5_hit",   q1_hit, 0);
        offer(4'd2, 16'h00AA);
        check("s5_next_we",   WriteReg, 1);
        check("s5_next_reg",  DstReg, 2);
        check("s5_next_data", DstData, 16'h00AA);
        tick();
        check("s5_drained", count, 0);

        // Randomised traffic against a reference queue
        mq_reg.delete();
        mq_dat.delete();
        for (int c = 0; c < 1000; c++) begin
            logic        expWe;
            logic        expReady;
            logic        expHit;
            logic [15:0] expData;
            in_valid = 1'($urandom_range(0, 1));
            in_reg   = 4'($urandom_range(0, 15));
            in_data  = 16'($urandom);
            drain_en = ($urandom_range(0, 2) != 0);
            q1_reg   = 4'($urandom_range(0, 15));
            q2_reg   = in_reg;
            #1;
            expWe    = drain_en && (mq_reg.size() != 0);
            expReady = (mq_reg.size() < DEPTH) || expWe;
            check("rnd_we",    WriteReg, 32'(expWe));
            check("rnd_ready", in_ready, 32'(expReady));
            if (expWe) begin
                check("rnd_reg",  DstReg, 32'(mq_reg[0]));
                check("rnd_data", DstData, 32'(mq_dat[0]));
            end
            modelLookup(q1_reg, expHit, expData);
            check("rnd_q1_hit",  q1_hit, 32'(expHit));
            check("rnd_q1_data", q1_data, 32'(expData));
            if (expWe) begin
                void'(mq_reg.pop_front());
                void'(mq_dat.pop_front());
            end
            if (in_valid && expReady && in_reg != 0) begin
                mq_reg.push_back(in_reg);
                mq_dat.push_back(in_data);
            end
            tick();
            check("rnd_count", count, 32'(mq_reg.size()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", r_checks, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
